// File: rtl/mem_bus_ctrl.sv
// Sequencer for a nibble-wide RAM on a shared bidirectional data bus.
// Optional write readback check is enabled by defining MEMCTRL_WRITE_VERIFY_EN.
module mem_bus_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              write_enable
);

    // state  | meaning
    // IDLE   | waiting for a request; only state where req_ready is high
    // WRITE  | address and data on the bus, write strobe high for one cycle
    // READ   | bus released, RAM data sampled at the end of the cycle
    // VERIFY | bus released after a write, readback compared to the written nibble
    // DONE   | one-cycle response pulse; also the bus turnaround cycle
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WRITE  = 3'd1;
    localparam logic [2:0] READ   = 3'd2;
    localparam logic [2:0] VERIFY = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            address   <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        address <= req_addr;
                        wdata_q <= req_wdata;
                        state   <= req_we ? WRITE : READ;
                    end
                end
                WRITE: begin
`ifdef MEMCTRL_WRITE_VERIFY_EN
                    state <= VERIFY;
`else
                    state <= DONE;
`endif
                end
                READ: begin
                    rsp_rdata <= data_bus;
                    state     <= DONE;
                end
                VERIFY: begin
                    rsp_rdata <= data_bus;
                    state     <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEMCTRL_WRITE_VERIFY_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == READ) begin
            err_q <= 1'b0;
        end else if (state == VERIFY) begin
            err_q <= (data_bus != wdata_q);
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready    = (state == IDLE) && rst_n;
    assign rsp_valid    = (state == DONE);
    assign write_enable = (state == WRITE);
    // Bus is only ever driven together with the write strobe.
    assign data_bus     = write_enable ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: RAM model on the shared bus, scoreboard of responses.
// Define MEMCTRL_WRITE_VERIFY_EN to exercise the write readback path.
module tb_mem_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [3:0] req_wdata = 4'h0;
    logic       rsp_valid;
    logic [3:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] address;
    wire  [3:0] data_bus;
    logic       write_enable;

    mem_bus_ctrl #(.ADDR_W(8), .DATA_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address(address), .data_bus(data_bus), .write_enable(write_enable)
    );

    always #5 clk = ~clk;

`ifdef MEMCTRL_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
    localparam int WR_LAT = 3;
`else
    localparam bit VFY = 1'b0;
    localparam int WR_LAT = 2;
`endif

    typedef struct {
        logic [3:0] rdata;
        logic       err;
        int         acc;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rsp_count = 0;
    logic [3:0] last_exp = 4'h0;
    logic [3:0] wr_data_exp = 4'h0;
    logic [7:0] wr_addr_exp = 8'h00;
    logic       prev_rsp = 1'b0;
    logic       prev_we = 1'b0;

    // RAM model: captures on the strobe edge, drives read data only in the
    // cycle the controller samples it and a quiet zero otherwise.
    logic [3:0] mem [256];
    logic [3:0] mem_mask = 4'hF;
    logic       acc_rd = 1'b0, acc_vf = 1'b0;
    logic       rd_win = 1'b0, vf1 = 1'b0, vf_win = 1'b0;
    logic [3:0] ram_drv;

    assign ram_drv  = (rd_win || vf_win) ? mem[address] : 4'h0;
    assign data_bus = write_enable ? 4'bzzzz : ram_drv;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (write_enable) mem[address] <= data_bus & mem_mask;
        rd_win <= rst_n && acc_rd;
        vf1    <= rst_n && acc_vf;
        vf_win <= rst_n && vf1;
    end

    // Response scoreboard, bus monitor and acceptance capture.
    always @(negedge clk) begin
        acc_rd = 1'b0;
        acc_vf = 1'b0;
        if (rsp_valid) begin
            rsp_count = rsp_count + 1;
            n_cmp = n_cmp + 1;
            if (sb.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, expected no response", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_cmp = n_cmp + 3;
                if (rsp_rdata !== e.rdata) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rsp_rdata: got %h, expected %h", rsp_rdata, e.rdata);
                end
                if (rsp_err !== e.err) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rsp_err: got %b, expected %b", rsp_err, e.err);
                end
                if (cyc + 1 - e.acc != e.lat) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rsp_latency: got E+%0d, expected E+%0d", cyc + 1 - e.acc, e.lat);
                end
            end
        end
        n_cmp = n_cmp + 1;
        if (rsp_valid && (prev_rsp || write_enable)) begin
            n_fail = n_fail + 1;
            $display("FAIL rsp_pulse: rsp_valid=%b prev=%b we=%b, expected single isolated pulse",
                     rsp_valid, prev_rsp, write_enable);
        end
        n_cmp = n_cmp + 1;
        if (write_enable) begin
            if (prev_we || data_bus !== wr_data_exp || address !== wr_addr_exp) begin
                n_fail = n_fail + 1;
                $display("FAIL bus_write: we_prev=%b bus=%h addr=%h, expected single strobe bus=%h addr=%h",
                         prev_we, data_bus, address, wr_data_exp, wr_addr_exp);
            end
        end else if (data_bus !== ram_drv) begin
            n_fail = n_fail + 1;
            $display("FAIL bus_idle: bus=%h with write_enable=0, expected only RAM value %h",
                     data_bus, ram_drv);
        end
        prev_rsp = rsp_valid;
        prev_we  = write_enable;
        if (rst_n && req_valid && req_ready) begin
            exp_t e;
            e.acc = cyc + 1;
            if (req_we) begin
                wr_data_exp = req_wdata;
                wr_addr_exp = req_addr;
                e.lat = WR_LAT;
                if (VFY) begin
                    e.rdata = req_wdata & mem_mask;
                    e.err   = (e.rdata != req_wdata);
                    last_exp = e.rdata;
                    acc_vf = 1'b1;
                end else begin
                    e.rdata = last_exp;
                    e.err   = 1'b0;
                end
            end else begin
                e.rdata = mem[req_addr];
                e.err   = 1'b0;
                e.lat   = 2;
                last_exp = e.rdata;
                acc_rd = 1'b1;
            end
            sb.push_back(e);
        end
    end

    // Presents one request and returns right after the accepting edge.
    task automatic issue(input bit we, input logic [7:0] a, input logic [3:0] d, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!got && n < 20) begin
            @(negedge clk);
            got = req_ready;
            n = n + 1;
            @(posedge clk); #1;
        end
        n_cmp = n_cmp + 1;
        if (!got) begin
            n_fail = n_fail + 1;
            $display("FAIL accept_timeout: req_ready never seen for addr %h, expected within 20 cycles", a);
        end
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(1));
        req_addr  = 8'($urandom);
        req_wdata = 4'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        n_cmp = n_cmp + 1;
        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h33;
        @(negedge clk);
        n_cmp = n_cmp + 5;
        if (req_ready !== 1'b0 || write_enable !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_ctrl: ready=%b we=%b rsp=%b, expected 0 0 0", req_ready, write_enable, rsp_valid);
        end
        if (address !== 8'h00) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_addr: got %h, expected 00", address);
        end
        if (rsp_rdata !== 4'h0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_rdata: got %h, expected 0", rsp_rdata);
        end
        if (rsp_err !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_err: got %b, expected 0", rsp_err);
        end
        if (data_bus !== 4'h0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_bus: got %h, expected released bus", data_bus);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_exp = 4'h0;
        issue(1'b0, 8'h33, 4'h0, n);
        n_cmp = n_cmp + 1;
        if (n != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL first_accept: accepted after %0d cycles, expected 1", n);
        end
        wait_idle();
    endtask

    task automatic test_write_read();
        int n, c0;
        c0 = rsp_count;
        issue(1'b1, 8'h0A, 4'hA, n);
        issue(1'b0, 8'h0A, 4'h0, n);
        wait_idle();
        n_cmp = n_cmp + 1;
        if (rsp_count - c0 != 2) begin
            n_fail = n_fail + 1;
            $display("FAIL wr_rd_count: got %0d responses, expected 2", rsp_count - c0);
        end
    endtask

    task automatic test_boundary();
        int n, c0;
        c0 = rsp_count;
        issue(1'b1, 8'hFF, 4'h5, n);
        issue(1'b1, 8'h00, 4'h3, n);
        issue(1'b0, 8'hFF, 4'h0, n);
        issue(1'b0, 8'h00, 4'h0, n);
        issue(1'b1, 8'h0A, 4'hC, n);
        issue(1'b0, 8'h0A, 4'h0, n);
        wait_idle();
        n_cmp = n_cmp + 2;
        if (rsp_count - c0 != 6) begin
            n_fail = n_fail + 1;
            $display("FAIL boundary_count: got %0d responses, expected 6", rsp_count - c0);
        end
        if (mem[8'hFF] !== 4'h5 || mem[8'h00] !== 4'h3) begin
            n_fail = n_fail + 1;
            $display("FAIL boundary_ram: mem[FF]=%h mem[00]=%h, expected 5 3", mem[8'hFF], mem[8'h00]);
        end
    endtask

    task automatic test_back_to_back();
        int rdy[$];
        int acc, c0, high;
        acc = 0; high = 0;
        c0 = rsp_count;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        for (int i = 0; i < 30 && acc < 4; i++) begin
            @(negedge clk);
            if (req_ready) begin
                rdy.push_back(cyc);
                high = high + 1;
            end
            @(posedge clk); #1;
            if (rdy.size() > acc) begin
                acc = acc + 1;
                req_addr = 8'h10 + 8'(acc * 17);
            end
        end
        req_valid = 1'b0;
        wait_idle();
        n_cmp = n_cmp + 3;
        if (high != 4) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_ready: ready high in %0d cycles, expected 4", high);
        end
        for (int i = 1; i < rdy.size(); i++) begin
            n_cmp = n_cmp + 1;
            if (rdy[i] - rdy[i-1] != 3) begin
                n_fail = n_fail + 1;
                $display("FAIL b2b_gap: ready spacing %0d, expected 3", rdy[i] - rdy[i-1]);
            end
        end
        if (rsp_count - c0 != 4) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_rsp: got %0d responses, expected 4", rsp_count - c0);
        end
        if (sb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_left: %0d responses outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int n, c0;
        issue(1'b1, 8'h44, 4'h9, n);
        c0 = rsp_count;
        rst_n = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        last_exp = 4'h0;
        @(negedge clk);
        n_cmp = n_cmp + 2;
        if (write_enable !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL abort_ctrl: we=%b ready=%b rsp=%b, expected 0 0 0", write_enable, req_ready, rsp_valid);
        end
        if (data_bus !== 4'h0) begin
            n_fail = n_fail + 1;
            $display("FAIL abort_bus: got %h, expected released bus", data_bus);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if (req_ready !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL abort_ready: got %b, expected 1", req_ready);
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp = n_cmp + 1;
        if (rsp_count != c0) begin
            n_fail = n_fail + 1;
            $display("FAIL abort_rsp: %0d responses after abort, expected 0", rsp_count - c0);
        end
        issue(1'b0, 8'h00, 4'h0, n);
        wait_idle();
    endtask

`ifdef MEMCTRL_WRITE_VERIFY_EN
    task automatic test_verify();
        int n, c0;
        c0 = rsp_count;
        mem_mask = 4'hE;
        issue(1'b1, 8'h0A, 4'h5, n);
        wait_idle();
        mem_mask = 4'hF;
        issue(1'b1, 8'h0B, 4'h7, n);
        issue(1'b0, 8'h0B, 4'h0, n);
        wait_idle();
        n_cmp = n_cmp + 1;
        if (rsp_count - c0 != 3) begin
            n_fail = n_fail + 1;
            $display("FAIL verify_count: got %0d responses, expected 3", rsp_count - c0);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 4'(i) ^ 4'h6;
        test_reset();
        test_write_read();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
`ifdef MEMCTRL_WRITE_VERIFY_EN
        test_verify();
`endif
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
